pwm_cfg_sched: RTL
==================

PWM_CFG_SCHED -- requirements
Module: pwm_cfg_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  in  1  requester has a write pending.
REQ-005 SHALL have ports req0_ready / req1_ready  out  1  write accepted this edge when ready&valid.
REQ-006 SHALL have ports req0_sel / req1_sel  in  2  target register: 01=cmp, 10=top, 11=cnt, 00=no-op.
REQ-007 SHALL have ports req0_data / req1_data  in  16  value to write.
REQ-008 SHALL have port pwm_cnt  in  16  live counter from PWM block.
REQ-009 SHALL have port pwm_top  in  16  live top from PWM block.
REQ-010 SHALL have port sel  out  2  PWM select, registered.
REQ-011 SHALL have port d  out  16  PWM write data, registered.
REQ-012 SHALL have port level  out  log2(DEPTH)+1  FIFO occupancy, registered.
REQ-013 SHALL have port busy  out  1  level!=0 or sel!=00.

Function
REQ-014 SHALL grant at most one requester per cycle.
REQ-015 SHALL assert reqN_ready only when reqN_valid, reqN is granted, and level<DEPTH (registered level; no push while full even if popping).
REQ-016 Arbitration: single valid requester granted; both valid -> requester not last accepted is granted (round-robin).
REQ-017 Last-accepted pointer SHALL update only on an accepted transfer.
REQ-018 Accepted request with sel=00 SHALL be consumed (ready asserted) but not stored; level unchanged; pointer still updates.
REQ-019 Accepted non-00 request SHALL be written to FIFO tail at the accepting edge; FIFO order preserved.
REQ-020 At each edge, if FIFO non-empty and head eligible, head SHALL be popped and driven on sel/d for exactly one cycle.
REQ-021 If no pop at an edge, sel SHALL be 00 and d SHALL be 0 for the following cycle.
REQ-022 Minimum latency: accepted at edge N -> sel/d valid from edge N+1 to N+2 (PWM captures at N+2).
REQ-023 Back-to-back pops SHALL be allowed, one entry per cycle.
REQ-024 Simultaneous push and pop SHALL leave level unchanged.
REQ-025 Head with sel=11 (cnt write) SHALL always be eligible.
REQ-026 A non-eligible head SHALL block all later entries (no reordering).
REQ-027 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.

Reset
REQ-028 rst_n low SHALL asynchronously clear: sel=00, d=0, level=0, FIFO pointers=0, last-accepted pointer=req1 (so req0 wins first tie).
REQ-029 During reset reqN_ready SHALL be 0; FIFO contents discarded; reset mid-operation loses all queued writes.
REQ-030 First edge after rst_n deasserts SHALL behave as a normal cycle.

Configuration
REQ-031 Macro PWM_SYNC_UPDATE_EN defined: head with sel=01 or 10 SHALL be eligible only when pwm_top==0 or pwm_cnt>=pwm_top (period boundary), evaluated at the popping edge.
REQ-032 Macro PWM_SYNC_UPDATE_EN undefined: every head SHALL be eligible immediately; pwm_cnt/pwm_top unused.

Verification
REQ-033 Reset, then req0 {01,0x0005} alone -> req0_ready=1 cycle 0; sel=01,d=0x0005 one cycle after; level returns 0.
REQ-034 Both valid every cycle, req0 {10,0x0010}, req1 {01,0x0008} -> grants alternate req0,req1,req0...; sel sequence 10,01,10 in order.
REQ-035 Hold output draining off (sync mode, pwm_cnt=0,pwm_top=100), push 4 cmp writes -> level=4, both readys 0 on 5th attempt; drive pwm_cnt=100 -> 4 consecutive cycles sel=01 in push order.
REQ-036 Sync mode, head {11,0x0000} with pwm_cnt=3,pwm_top=50 -> issued next cycle; following {01,0x0020} waits until pwm_cnt=50.
REQ-037 req1 {00,0xFFFF} -> ready=1, level stays 0, sel stays 00; next tie goes to req0.
REQ-038 Push 3 entries, assert rst_n low mid-drain -> sel=00,level=0 immediately; after release no stale writes appear.

Source files
------------

// File: rtl/pwm_cfg_sched.sv
// rtl/pwm_cfg_sched.sv - two-requester PWM register write scheduler with FIFO; optional PWM_SYNC_UPDATE_EN
module pwm_cfg_sched #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [1:0]              req0_sel,
  input  logic [15:0]             req0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [1:0]              req1_sel,
  input  logic [15:0]             req1_data,
  input  logic [15:0]             pwm_cnt,
  input  logic [15:0]             pwm_top,
  output logic [1:0]              sel,
  output logic [15:0]             d,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // FIFO entry layout: {sel[1:0], data[15:0]}
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // 1 = req1 was the last accepted requester, so req0 wins the next tie
  logic          last_q;

  logic          not_full;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [1:0]    acc_sel;
  logic [15:0]   acc_data;
  logic          push;
  logic [17:0]   head;
  logic          head_ok;
  logic          pop;

  // Full check uses the registered level only, so a same-edge pop never frees a slot early
  assign not_full = (level < LW'(DEPTH));

  // Round-robin between the two requesters; a lone requester always wins
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  // Ready is forced low while reset is held even though level already reads zero
  assign req0_ready = grant0 && not_full && rst_n;
  assign req1_ready = grant1 && not_full && rst_n;

  assign accept   = req0_ready || req1_ready;
  assign acc_sel  = req0_ready ? req0_sel  : req1_sel;
  assign acc_data = req0_ready ? req0_data : req1_data;

  // sel=00 requests are handshaken but never stored
  assign push = accept && (acc_sel != 2'b00);

  assign head = mem[rd_ptr];

`ifdef PWM_SYNC_UPDATE_EN
  // cmp/top writes wait for a period boundary; cnt writes go out immediately
  assign head_ok = (head[17:16] == 2'b11) || (pwm_top == 16'd0) || (pwm_cnt >= pwm_top);
`else
  // Every head is eligible at once; the PWM live values are not needed
  logic unused_pwm;
  assign unused_pwm = ^{pwm_cnt, pwm_top, head[17:16]};
  assign head_ok    = 1'b1;
`endif

  assign pop = (level != '0) && head_ok;

  assign busy = (level != '0) || (sel != 2'b00);

  // FIFO storage write; contents need no reset because pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {acc_sel, acc_data};
    end
  end

  // Pointers, occupancy, arbitration history and the one-cycle PWM write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      last_q <= 1'b1;
      sel    <= 2'b00;
      d      <= 16'd0;
    end else begin
      if (accept) begin
        last_q <= req1_ready;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        sel    <= head[17:16];
        d      <= head[15:0];
      end else begin
        sel    <= 2'b00;
        d      <= 16'd0;
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
